// File: rtl/win_sum_pkg.sv
// Shared helpers and width derivations for the multi-channel moving-window sum.
// Optional feature macro: WSUM_FLUSH_EN (adds a per-channel flush input).
package win_sum_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Result width that can never overflow: window of full-scale samples.
  function automatic int sum_width(input int data_w, input int win);
    return data_w + clog2(win);
  endfunction

  // Default configuration derivations.
  localparam int CH_NUM_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int WIN_DEF    = 8;
  localparam int CH_W       = clog2(CH_NUM_DEF);
  localparam int PTR_W      = clog2(WIN_DEF);
  localparam int SUM_W      = sum_width(DATA_W_DEF, WIN_DEF);

  typedef logic [CH_W-1:0] ch_idx_t;

endpackage

// File: rtl/win_sum_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr (mod N) wins.
module win_sum_rr_arb
  import win_sum_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int            c;
  logic          found;
  logic [IW-1:0] cidx;

  // Scan from ptr with wraparound; first hit is the one-hot grant.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    cidx  = '0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      cidx = IW'(c);
      if (en && !found && req[cidx]) begin
        found     = 1'b1;
        gnt[cidx] = 1'b1;
        idx       = cidx;
      end
    end
  end

endmodule

// File: rtl/win_sum_sched.sv
// Moving-window sum shared round-robin across CH_NUM sample channels.
// Each channel keeps its own WIN-deep history, write pointer and running sum;
// one sample is accepted per cycle and its new sum appears one cycle later.
// Optional feature macro: WSUM_FLUSH_EN (per-channel flush input).
module win_sum_sched
  import win_sum_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int DATA_W = 8,
  parameter int WIN    = 8,
  localparam int CHW   = clog2(CH_NUM),
  localparam int PW    = clog2(WIN),
  localparam int SW    = sum_width(DATA_W, WIN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CH_NUM-1:0]        req_valid,
  input  logic [CH_NUM*DATA_W-1:0] req_data,
  output logic [CH_NUM-1:0]        req_ready,
`ifdef WSUM_FLUSH_EN
  input  logic [CH_NUM-1:0]        flush,
`endif
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [CHW-1:0]           o_ch,
  output logic [SW-1:0]            o_y
);

  logic [CH_NUM-1:0][WIN-1:0][DATA_W-1:0] hist_q;
  logic [CH_NUM-1:0][PW-1:0]              wp_q;
  logic [CH_NUM-1:0][SW-1:0]              sum_q;
  logic [CHW-1:0]                         rr_q, rr_d;
  logic                                   ov_q, ov_d;
  logic [CHW-1:0]                         och_q, och_d;
  logic [SW-1:0]                          oy_q, oy_d;

  logic [CH_NUM-1:0] flush_m, cand, gnt;
  logic [CHW-1:0]    gidx;
  logic              stall, arb_en, any_gnt;
  logic [DATA_W-1:0] x, old;
  logic [SW-1:0]     new_sum;

`ifdef WSUM_FLUSH_EN
  assign flush_m = flush;
`else
  assign flush_m = '0;
`endif

  // Nothing is granted while the result register is blocked or in reset;
  // flushed channels sit out arbitration for the flush cycle.
  always_comb begin
    stall  = ov_q & ~o_ready;
    arb_en = rst_n & ~stall;
    cand   = req_valid & ~flush_m;
  end

  win_sum_rr_arb #(.N(CH_NUM)) u_arb (
    .req (cand),
    .ptr (rr_q),
    .en  (arb_en),
    .gnt (gnt),
    .idx (gidx)
  );

  assign req_ready = gnt;
  assign o_valid   = ov_q;
  assign o_ch      = och_q;
  assign o_y       = oy_q;

  // Shared datapath: evict the oldest sample of the granted channel, add the new one.
  // sum >= any single history entry, so the subtraction cannot underflow.
  always_comb begin
    any_gnt = |gnt;
    x       = req_data[int'(gidx)*DATA_W +: DATA_W];
    old     = hist_q[gidx][wp_q[gidx]];
    new_sum = sum_q[gidx] + SW'(x) - SW'(old);
    rr_d    = rr_q;
    if (any_gnt) rr_d = (int'(gidx) == CH_NUM-1) ? '0 : gidx + CHW'(1);
  end

  // Result register: hold while stalled, load on grant, otherwise drain.
  always_comb begin
    ov_d  = ov_q;
    och_d = och_q;
    oy_d  = oy_q;
    if (!stall) begin
      if (any_gnt) begin
        ov_d  = 1'b1;
        och_d = gidx;
        oy_d  = new_sum;
      end else begin
        ov_d  = 1'b0;
      end
    end
  end

  // Per-channel history, pointer and running sum; flush wins over a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      wp_q   <= '0;
      sum_q  <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (flush_m[i]) begin
          hist_q[i] <= '0;
          wp_q[i]   <= '0;
          sum_q[i]  <= '0;
        end else if (gnt[i]) begin
          hist_q[i][wp_q[i]] <= x;
          wp_q[i]            <= wp_q[i] + PW'(1);
          sum_q[i]           <= new_sum;
        end
      end
    end
  end

  // Arbitration pointer and output register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q  <= '0;
      ov_q  <= 1'b0;
      och_q <= '0;
      oy_q  <= '0;
    end else begin
      rr_q  <= rr_d;
      ov_q  <= ov_d;
      och_q <= och_d;
      oy_q  <= oy_d;
    end
  end

endmodule

// File: tb/tb_win_sum_sched.sv
// Directed, table-driven bench for win_sum_sched (default 4 ch, 8-bit, WIN=8).
module tb_win_sum_sched;
  import win_sum_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        o_valid;
  logic        o_ready;
  logic [1:0]  o_ch;
  logic [10:0] o_y;
`ifdef WSUM_FLUSH_EN
  logic [3:0]  flush;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  win_sum_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
`ifdef WSUM_FLUSH_EN
    .flush     (flush),
`endif
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_ch      (o_ch),
    .o_y       (o_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;   // pulse reset before applying this vector
    logic [3:0]  v;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  er;    // expected req_ready with these inputs
    logic        ev;    // expected o_valid after the edge
    ch_idx_t     ech;
    logic [10:0] ey;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] pk(input int d0, input int d1, input int d2, input int d3);
    return {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    chk("async_rst_o_valid", int'(o_valid), 0);
    chk("async_rst_o_y", int'(o_y), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input vec_t t);
    @(negedge clk);
    req_valid = t.v;
    req_data  = t.d;
    o_ready   = t.ordy;
    #1;
    chk("req_ready", int'(req_ready), int'(t.er));
    @(posedge clk);
    #1;
    chk("o_valid", int'(o_valid), int'(t.ev));
    if (t.ev) begin
      chk("o_ch", int'(o_ch), int'(t.ech));
      chk("o_y", int'(o_y), int'(t.ey));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp2[10] = '{1, 3, 6, 10, 15, 21, 28, 36, 44, 52};
    int exp4[12] = '{255, 510, 765, 1020, 1275, 1530, 1785, 2040, 2040, 2040, 2040, 2040};
    int y3[4]    = '{0, 0, 0, 0};
    logic [3:0] oh;

    // Test 1: reset held with every channel requesting
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_data  = pk(1, 2, 3, 4);
    o_ready   = 1'b1;
`ifdef WSUM_FLUSH_EN
    flush     = '0;
`endif
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_o_valid", int'(o_valid), 0);
      chk("rst_o_y", int'(o_y), 0);
      chk("rst_o_ch", int'(o_ch), 0);
      #4;
    end
    #1;               // t = 22
    req_valid = '0;
    rst_n     = 1'b1;

    // Test 2: ch0 alone, 1..10
    for (int k = 0; k < 10; k++)
      tbl.push_back('{1'b0, 4'b0001, pk(k + 1, 0, 0, 0), 1'b1, 4'b0001, 1'b1, 2'd0, 11'(exp2[k])});
    tbl.push_back('{1'b0, 4'b0000, 32'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 11'd0});

    // Test 3: all four channels, constant data 10/20/30/40
    for (int k = 0; k < 12; k++) begin
      oh = 4'b0001 << (k % 4);
      y3[k % 4] = y3[k % 4] + 10 * (k % 4 + 1);
      tbl.push_back('{k == 0, 4'b1111, pk(10, 20, 30, 40), 1'b1, oh, 1'b1, 2'(k % 4), 11'(y3[k % 4])});
    end

    // Test 4: ch2 full-scale samples saturate the window at 2040
    for (int k = 0; k < 12; k++)
      tbl.push_back('{k == 0, 4'b0100, pk(0, 0, 255, 0), 1'b1, 4'b0100, 1'b1, 2'd2, 11'(exp4[k])});

    // Test 5: ch0 and ch1 streaming with a 3-cycle downstream stall
    tbl.push_back('{1'b1, 4'b0011, pk(1, 100, 0, 0), 1'b1, 4'b0001, 1'b1, 2'd0, 11'd1});
    tbl.push_back('{1'b0, 4'b0011, pk(2, 100, 0, 0), 1'b1, 4'b0010, 1'b1, 2'd1, 11'd100});
    tbl.push_back('{1'b0, 4'b0011, pk(2, 101, 0, 0), 1'b0, 4'b0000, 1'b1, 2'd1, 11'd100});
    tbl.push_back('{1'b0, 4'b0011, pk(2, 101, 0, 0), 1'b0, 4'b0000, 1'b1, 2'd1, 11'd100});
    tbl.push_back('{1'b0, 4'b0011, pk(2, 101, 0, 0), 1'b0, 4'b0000, 1'b1, 2'd1, 11'd100});
    tbl.push_back('{1'b0, 4'b0011, pk(2, 101, 0, 0), 1'b1, 4'b0001, 1'b1, 2'd0, 11'd3});
    tbl.push_back('{1'b0, 4'b0011, pk(3, 101, 0, 0), 1'b1, 4'b0010, 1'b1, 2'd1, 11'd201});
    tbl.push_back('{1'b0, 4'b0011, pk(3, 102, 0, 0), 1'b1, 4'b0001, 1'b1, 2'd0, 11'd6});
    tbl.push_back('{1'b0, 4'b0011, pk(4, 102, 0, 0), 1'b1, 4'b0010, 1'b1, 2'd1, 11'd303});
    tbl.push_back('{1'b0, 4'b0000, 32'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 11'd0});

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i]);
    end

`ifdef WSUM_FLUSH_EN
    // Test 6: ch1 history sums to 100, flush, then a fresh sample of 5
    do_reset();
    step('{1'b0, 4'b0010, pk(0, 40, 0, 0), 1'b1, 4'b0010, 1'b1, 2'd1, 11'd40});
    step('{1'b0, 4'b0010, pk(0, 60, 0, 0), 1'b1, 4'b0010, 1'b1, 2'd1, 11'd100});
    @(negedge clk);
    flush     = 4'b0010;
    req_valid = 4'b0010;
    req_data  = pk(0, 77, 0, 0);
    #1;
    chk("flush_req_ready", int'(req_ready), 0);
    @(posedge clk);
    #1;
    chk("flush_o_valid", int'(o_valid), 0);
    @(negedge clk);
    flush = '0;
    step('{1'b0, 4'b0010, pk(0, 5, 0, 0), 1'b1, 4'b0010, 1'b1, 2'd1, 11'd5});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
